// File: rtl/golden_nonce_tx.sv
// golden_nonce_tx: queues golden nonces and sends each one as
// four 8N1 UART bytes, most-significant stored byte first.
module golden_nonce_tx #(
  parameter int unsigned BAUD_DIV  = 434,
  parameter int unsigned FIFO_LOG2 = 2,
  parameter bit          BYTESWAP  = 1'b1
) (
  input  logic                 hash_clk,
  input  logic                 reset_n,
  input  logic [31:0]          golden_nonce,
  input  logic                 golden_nonce_valid,
  output logic                 uart_tx,
  output logic                 busy,
  output logic                 overflow,
  output logic [FIFO_LOG2:0]   fifo_level
);

  localparam int unsigned DEPTH = 1 << FIFO_LOG2;
  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e             state_q, state_d;
  logic [15:0]        baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [1:0]         byte_q, byte_d;
  logic [31:0]        shreg_q, shreg_d;
  logic               tx_q, tx_d;
  logic               ovf_q, ovf_d;
  logic [FIFO_LOG2:0] wptr_q, rptr_q;
  logic [31:0]        mem_q [DEPTH];

  logic        empty, full, pop, push, bit_end;
  logic [31:0] wdata;

  assign wdata = BYTESWAP ? {golden_nonce[7:0], golden_nonce[15:8],
                             golden_nonce[23:16], golden_nonce[31:24]}
                          : golden_nonce;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[FIFO_LOG2] != rptr_q[FIFO_LOG2]) &&
                 (wptr_q[FIFO_LOG2-1:0] == rptr_q[FIFO_LOG2-1:0]);
  assign pop   = (state_q == IDLE) && !empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign push  = golden_nonce_valid && (!full || pop);
  assign ovf_d = ovf_q | (golden_nonce_valid & full & ~pop);

  assign bit_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shreg_d = shreg_q;
    tx_d    = 1'b1;
    if (state_q != IDLE) begin
      baud_d = bit_end ? 16'd0 : baud_q + 16'd1;
    end
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          shreg_d = mem_q[rptr_q[FIFO_LOG2-1:0]];
          byte_d  = 2'd0;
          baud_d  = 16'd0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_d   = 3'd0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (byte_q != 2'd3) begin
            byte_d  = byte_q + 2'd1;
            shreg_d = shreg_q << 8;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Line value is registered, so it is derived from the next state.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[{2'b11, bit_d}];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge hash_clk) begin
    if (push) mem_q[wptr_q[FIFO_LOG2-1:0]] <= wdata;
  end

  assign uart_tx    = tx_q;
  assign overflow   = ovf_q;
  assign fifo_level = wptr_q - rptr_q;
  assign busy       = (state_q != IDLE) | (fifo_level != '0);

endmodule

// File: tb/tb_golden_nonce_tx.sv
// tb_golden_nonce_tx: table vectors plus corner sequences; a UART
// monitor decodes each line and checks bytes against a queue.
module tb_golden_nonce_tx;

  localparam int B = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] nonce = '0;
  logic        va = 1'b0, vb = 1'b0;
  logic        txa, busya, ovfa;
  logic [1:0]  lvla;
  logic        txb, busyb, ovfb;
  logic [2:0]  lvlb;

  int ncmp = 0;
  int nerr = 0;
  int cyc = 0;

  logic [7:0] expq [2][$];
  int         starts [2][$];
  int         mcnt [2] = '{-1, -1};
  logic [9:0] mbits [2];
  logic       mbad [2];

  typedef struct {
    int          d;
    logic [31:0] n;
    logic [31:0] w;
  } vec_t;

  golden_nonce_tx #(.BAUD_DIV(B), .FIFO_LOG2(1), .BYTESWAP(1'b1)) dut_a (
    .hash_clk(clk), .reset_n(rst_n), .golden_nonce(nonce),
    .golden_nonce_valid(va), .uart_tx(txa), .busy(busya),
    .overflow(ovfa), .fifo_level(lvla)
  );

  golden_nonce_tx #(.BAUD_DIV(B), .FIFO_LOG2(2), .BYTESWAP(1'b0)) dut_b (
    .hash_clk(clk), .reset_n(rst_n), .golden_nonce(nonce),
    .golden_nonce_valid(vb), .uart_tx(txb), .busy(busyb),
    .overflow(ovfb), .fifo_level(lvlb)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic tx_of(input int d);
    return (d == 0) ? txa : txb;
  endfunction

  function automatic logic busy_of(input int d);
    return (d == 0) ? busya : busyb;
  endfunction

  function automatic int lvl_of(input int d);
    return (d == 0) ? int'(lvla) : int'(lvlb);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic rx_byte(input int d);
    logic [7:0] e;
    chk($sformatf("stopbit%0d", d), 32'(mbits[d][9]), 32'd1);
    chk($sformatf("bitwidth%0d", d), 32'(mbad[d]), 32'd0);
    if (expq[d].size() == 0) begin
      ncmp++;
      nerr++;
      $display("FAIL unexpected_byte%0d: got %h want none", d,
               mbits[d][8:1]);
    end else begin
      e = expq[d].pop_front();
      chk($sformatf("rxbyte%0d", d), 32'(mbits[d][8:1]), 32'(e));
    end
  endtask

  // Samples every cycle of every bit, so width errors are caught too.
  initial forever begin
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      logic t;
      t = tx_of(d);
      if (!rst_n) begin
        mcnt[d] = -1;
      end else if (mcnt[d] < 0) begin
        if (t == 1'b0) begin
          mcnt[d] = 1;
          mbits[d] = '0;
          mbad[d] = 1'b0;
          starts[d].push_back(cyc);
        end
      end else begin
        if (mcnt[d] % B == 0) mbits[d][mcnt[d] / B] = t;
        else if (t !== mbits[d][mcnt[d] / B]) mbad[d] = 1'b1;
        mcnt[d]++;
        if (mcnt[d] == 10 * B) begin
          mcnt[d] = -1;
          rx_byte(d);
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic sync_to(input int t);
    while (cyc < t) sync();
  endtask

  task automatic exp_word(input int d, input logic [31:0] w);
    for (int i = 3; i >= 0; i--) expq[d].push_back(w[i*8 +: 8]);
  endtask

  // Call just after a rising edge; returns cyc after the sampling edge.
  task automatic strobe(input int d, input logic [31:0] n, output int e0);
    nonce = n;
    va = (d == 0);
    vb = (d == 1);
    sync();
    e0 = cyc;
    va = 1'b0;
    vb = 1'b0;
  endtask

  task automatic wait_start(input int d, input int idx, output int s);
    int n;
    n = 0;
    while (starts[d].size() <= idx && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (starts[d].size() <= idx) begin
      chk("start_timeout", 32'(starts[d].size()), 32'(idx + 1));
      s = 0;
    end else begin
      s = starts[d][idx];
    end
  endtask

  task automatic wait_idle(input int d, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (n < budget && (busy_of(d) || mcnt[d] >= 0)) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("idle_timeout%0d", d), 32'(n < budget), 32'd1);
    chk($sformatf("leftover%0d", d), 32'(expq[d].size()), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_txa", 32'(txa), 32'd1);
    chk("rst_busya", 32'(busya), 32'd0);
    chk("rst_ovfa", 32'(ovfa), 32'd0);
    chk("rst_lvla", 32'(lvla), 32'd0);
    chk("rst_txb", 32'(txb), 32'd1);
    chk("rst_busyb", 32'(busyb), 32'd0);
    sync();
    rst_n = 1'b1;
    sync();
    starts[0].delete();
    starts[1].delete();
  endtask

  vec_t vt [3];
  int   e0, e1, s, s2;

  initial begin
    vt[0] = '{0, 32'h1DAC2B7C, 32'h7C2BAC1D};
    vt[1] = '{1, 32'h0E33337A, 32'h0E33337A};
    vt[2] = '{0, 32'hCAFEF00D, 32'h0DF0FECA};

    do_reset();

    for (int i = 0; i < 3; i++) begin
      starts[vt[i].d].delete();
      exp_word(vt[i].d, vt[i].w);
      strobe(vt[i].d, vt[i].n, e0);
      chk($sformatf("v%0d_lvl", i), 32'(lvl_of(vt[i].d)), 32'd1);
      wait_start(vt[i].d, 0, s);
      chk($sformatf("v%0d_start", i), 32'(s), 32'(e0 + 1));
      while (cyc < s + 159) @(negedge clk);
      chk($sformatf("v%0d_busy159", i), 32'(busy_of(vt[i].d)), 32'd1);
      @(negedge clk);
      chk($sformatf("v%0d_busy160", i), 32'(busy_of(vt[i].d)), 32'd0);
      chk($sformatf("v%0d_tx160", i), 32'(tx_of(vt[i].d)), 32'd1);
      wait_idle(vt[i].d, 400);
      sync();
    end

    // Back-to-back strobes on the deeper, non-swapping instance.
    starts[1].delete();
    exp_word(1, 32'h11111111);
    exp_word(1, 32'h22222222);
    exp_word(1, 32'h33333333);
    strobe(1, 32'h11111111, e0);
    chk("b2b_lvl1", 32'(lvlb), 32'd1);
    strobe(1, 32'h22222222, e1);
    chk("b2b_lvl2", 32'(lvlb), 32'd1);
    strobe(1, 32'h33333333, e1);
    chk("b2b_lvl3", 32'(lvlb), 32'd2);
    wait_idle(1, 700);
    chk("b2b_nbytes", 32'(starts[1].size()), 32'd12);
    if (starts[1].size() == 12) begin
      chk("b2b_gap1", 32'(starts[1][4] - starts[1][0]), 32'd161);
      chk("b2b_gap2", 32'(starts[1][8] - starts[1][4]), 32'd161);
      chk("b2b_byte_gap", 32'(starts[1][1] - starts[1][0]), 32'd40);
    end
    chk("b2b_ovf", 32'(ovfb), 32'd0);

    // Overflow on the two-entry FIFO.
    do_reset();
    exp_word(0, 32'h04030201);
    exp_word(0, 32'h14131211);
    exp_word(0, 32'h24232221);
    strobe(0, 32'h01020304, e0);
    chk("ovf_lvl1", 32'(lvla), 32'd1);
    strobe(0, 32'h11121314, e1);
    chk("ovf_lvl2", 32'(lvla), 32'd1);
    strobe(0, 32'h21222324, e1);
    chk("ovf_lvl3", 32'(lvla), 32'd2);
    chk("ovf_clr3", 32'(ovfa), 32'd0);
    strobe(0, 32'h31323334, e1);
    chk("ovf_set4", 32'(ovfa), 32'd1);
    chk("ovf_lvl4", 32'(lvla), 32'd2);
    strobe(0, 32'h41424344, e1);
    chk("ovf_set5", 32'(ovfa), 32'd1);
    wait_idle(0, 800);
    chk("ovf_nbytes", 32'(starts[0].size()), 32'd12);
    chk("ovf_sticky", 32'(ovfa), 32'd1);

    // Push lands in the IDLE pop cycle while the FIFO is full.
    do_reset();
    exp_word(0, 32'hA4A3A2A1);
    exp_word(0, 32'hB4B3B2B1);
    exp_word(0, 32'hC4C3C2C1);
    exp_word(0, 32'hD4D3D2D1);
    strobe(0, 32'hA1A2A3A4, e0);
    repeat (8) sync();
    strobe(0, 32'hB1B2B3B4, e1);
    strobe(0, 32'hC1C2C3C4, e1);
    chk("sim_full", 32'(lvla), 32'd2);
    sync_to(e0 + 161);
    strobe(0, 32'hD1D2D3D4, e1);
    chk("sim_lvl", 32'(lvla), 32'd2);
    chk("sim_ovf", 32'(ovfa), 32'd0);
    wait_start(0, 4, s2);
    chk("sim_gap", 32'(s2 - starts[0][0]), 32'd161);
    wait_idle(0, 900);
    chk("sim_ovf_end", 32'(ovfa), 32'd0);

    // Reset during data bit 3 of byte 1.
    do_reset();
    expq[0].push_back(8'h78);
    strobe(0, 32'h12345678, e0);
    wait_start(0, 0, s);
    while (cyc < s + 57) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_tx", 32'(txa), 32'd1);
    chk("mid_busy", 32'(busya), 32'd0);
    chk("mid_lvl", 32'(lvla), 32'd0);
    repeat (3) sync();
    rst_n = 1'b1;
    sync();
    chk("mid_leftover", 32'(expq[0].size()), 32'd0);
    starts[0].delete();
    exp_word(0, 32'hEFBEADDE);
    strobe(0, 32'hDEADBEEF, e0);
    wait_start(0, 0, s);
    chk("mid_restart", 32'(s), 32'(e0 + 1));
    wait_idle(0, 400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/golden_nonce_tx.md
# golden_nonce_tx

Serialises golden nonces from `fpgaminer_top` out of the FPGA over a UART line, 8N1. It sits between the miner core's result output (`golden_nonce` plus a one-cycle valid strobe) and the board's TX pin. It buffers results in a small FIFO so that back-to-back finds during a long frame are not lost. It optionally byte-swaps each nonce into block-header byte order.

## Interface
- `BAUD_DIV`, 434: hash_clk cycles per UART bit (115200 baud at 50 MHz); legal range 2..65535.
- `FIFO_LOG2`, 2: FIFO depth is 2^FIFO_LOG2 nonces; legal range 1..6.
- `BYTESWAP`, 1: 1 reverses byte order of each nonce before transmission; 0 sends it as received.
- `hash_clk` input 1: single clock, all logic rising-edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `golden_nonce` input 32: nonce from the miner core.
- `golden_nonce_valid` input 1: one-cycle strobe; `golden_nonce` is valid in that cycle.
- `uart_tx` output 1: serial line, idle high.
- `busy` output 1: high while a frame is in flight or the FIFO is non-empty.
- `overflow` output 1: sticky; set when a strobe arrives with the FIFO full and no pop in the same cycle.
- `fifo_level` output FIFO_LOG2+1: number of queued nonces, excluding the one being sent.

## Operation
- Reset values: `uart_tx`=1, `busy`=0, `overflow`=0, `fifo_level`=0. FSM goes to IDLE, FIFO pointers go to 0, baud counter goes to 0.
- Push: on a rising edge with `golden_nonce_valid`=1, the nonce is written to the FIFO. The written value is `{b0,b1,b2,b3}` when BYTESWAP=1 and the raw nonce otherwise.
- Full FIFO:
  - A push while full with no pop in the same cycle is dropped and sets `overflow`.
  - A push while full in the same cycle as a pop is accepted.
  - `overflow` clears only on reset.
- Frame: each nonce is 4 bytes, most-significant byte of the stored word first. Each byte is start(0), 8 data bits LSB-first, stop(1). Every bit lasts exactly BAUD_DIV cycles.
- FSM states:
  - IDLE: `uart_tx`=1. If the FIFO is non-empty, pop into a 32-bit shift register, set byte index 0, and go to START.
  - START: drive 0 for BAUD_DIV cycles, then go to DATA with bit index 0.
  - DATA: drive the current bit for BAUD_DIV cycles. Advance the bit index; after bit 7 go to STOP.
  - STOP: drive 1 for BAUD_DIV cycles. If byte index < 3, increment it, shift the next byte in, and go to START. Otherwise go to IDLE.
- No idle gap between the bytes of one nonce. Between nonces, the gap is exactly one cycle (the IDLE pop cycle).
- Counter widths:
  - Baud counter: 16 bits, counts 0..BAUD_DIV-1, and the bit period ends on the wrap.
  - Bit index: 3 bits.
  - Byte index: 2 bits.
  - FIFO pointers: FIFO_LOG2+1 bits with natural wrap. Full is when the MSBs differ and the rest are equal.
- `busy` = (state != IDLE) | (fifo_level != 0).

## Timing
- Strobe sampled at edge E0: `fifo_level` shows 1 after E0. FSM pops at E1.
- `uart_tx` is registered. When idle, it falls after E1, giving 2 cycles strobe-to-start-bit.
- Byte length is 10*BAUD_DIV cycles. Nonce length is 40*BAUD_DIV cycles. Consecutive queued nonces start every 40*BAUD_DIV+1 cycles.
- Push and pop in the same cycle with the FIFO non-full: `fifo_level` is unchanged.
- Strobe while IDLE with the FIFO empty: the push is still registered; the pop is always from the registered FIFO, never a bypass.
- `reset_n` low mid-frame: `uart_tx` goes to 1 and the FIFO empties asynchronously. The partial frame is abandoned and not resumed.
- `golden_nonce_valid` held high for N cycles pushes N entries, subject to full handling.

## Test plan
- Genesis nonce, BAUD_DIV=4, BYTESWAP=1: `golden_nonce`=0x1DAC2B7C, one strobe.
  - `uart_tx` falls 2 cycles later.
  - Decoded bytes are 0x7C,0x2B,0xAC,0x1D.
  - Line is back high and `busy`=0 exactly 160 cycles after the start-bit edge.
- BYTESWAP=0, BAUD_DIV=4: nonce 0x0E33337A, one strobe → bytes 0x0E,0x33,0x33,0x7A; each bit exactly 4 cycles wide.
- Back-to-back: strobes on 3 consecutive cycles with 0x11111111, 0x22222222, 0x33333333.
  - `fifo_level` peaks at 2.
  - All 12 bytes are received in order.
  - Start bits of successive nonces are 161 cycles apart.
  - `overflow`=0.
- Overflow, FIFO_LOG2=1: 5 strobes in consecutive cycles with distinct values.
  - First nonce is popped; next 2 are queued; remaining 2 are dropped.
  - `overflow`=1 from the first dropped cycle onward.
  - Exactly 3 nonces are transmitted.
- Simultaneous push/pop with the FIFO full, FIFO_LOG2=1: strobe lands in the IDLE pop cycle → push accepted, `overflow` stays 0, `fifo_level` stays 2.
- Reset mid-frame: assert `reset_n`=0 during DATA bit 3 of byte 1.
  - `uart_tx`=1, `busy`=0, `fifo_level`=0 before the next clock edge.
  - After release, a new strobe 0xDEADBEEF (BYTESWAP=1) transmits 0xEF,0xBE,0xAD,0xDE cleanly.
